// File: rtl/cam_table_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : cam_table_controller_if
// Brief    : Requester handshake and response bus of the CAM table controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cam_table_controller_if #(
  parameter int NUMBER_OF_PORTS = 2
);
  localparam int PORT_INDEX_WIDTH = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1;

  logic [NUMBER_OF_PORTS-1:0]       request_valid;
  logic [NUMBER_OF_PORTS-1:0]       request_learn;
  logic [NUMBER_OF_PORTS-1:0][47:0] request_mac;
  logic [NUMBER_OF_PORTS-1:0]       request_ready;
  logic                             response_valid;
  logic [PORT_INDEX_WIDTH-1:0]      response_requester;
  logic                             response_hit;
  logic [PORT_INDEX_WIDTH-1:0]      response_port;
  logic                             busy;

  modport master (
    output request_valid, request_learn, request_mac,
    input  request_ready, response_valid, response_requester,
    input  response_hit, response_port, busy
  );

  modport slave (
    input  request_valid, request_learn, request_mac,
    output request_ready, response_valid, response_requester,
    output response_hit, response_port, busy
  );
endinterface
`default_nettype wire

// File: rtl/cam_table_controller.sv
`default_nettype none
// ============================================================================
// Module   : cam_table_controller
// Brief    : Round-robin arbitrated MAC learn/lookup over an SRAM-backed CAM.
// Revision : 1.0 - initial release
// ============================================================================
module cam_table_controller #(
  parameter int NUMBER_OF_PORTS     = 2,
  parameter int TABLE_ADDRESS_WIDTH = 4
) (
  input  wire                            clock,
  input  wire                            reset_n,
  cam_table_controller_if.slave          bus,
  output logic [TABLE_ADDRESS_WIDTH-1:0] cam_table_read_address,
  input  wire  [47:0]                    cam_table_read_data,
  output logic [TABLE_ADDRESS_WIDTH-1:0] cam_table_write_address,
  output logic [47:0]                    cam_table_write_data,
  output logic                           cam_table_write_enable
);
  localparam int DEPTH       = 1 << TABLE_ADDRESS_WIDTH;
  localparam int PIW         = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1;
  localparam int COUNT_WIDTH = TABLE_ADDRESS_WIDTH + 1;

  localparam logic [1:0] c_state_idle    = 2'd0;
  localparam logic [1:0] c_state_scan    = 2'd1;
  localparam logic [1:0] c_state_update  = 2'd2;
  localparam logic [1:0] c_state_respond = 2'd3;

  logic [1:0]                     r_state;
  logic [COUNT_WIDTH-1:0]         r_count;
  logic [47:0]                    r_mac;
  logic                           r_learn;
  logic [PIW-1:0]                 r_requester;
  logic [PIW-1:0]                 r_next;
  logic [DEPTH-1:0]               r_valid;
  logic [PIW-1:0]                 r_port [DEPTH];
  logic [TABLE_ADDRESS_WIDTH-1:0] r_victim;
  logic                           r_hit;
  logic [TABLE_ADDRESS_WIDTH-1:0] r_hit_index;
  logic [PIW-1:0]                 r_hit_port;

  logic                           w_grant;
  logic [PIW-1:0]                 w_winner;
  logic [PIW-1:0]                 w_candidate;
  logic [TABLE_ADDRESS_WIDTH-1:0] w_compare_index;
  logic                           w_match;
  logic                           w_free_found;
  logic [TABLE_ADDRESS_WIDTH-1:0] w_free_index;
  logic [TABLE_ADDRESS_WIDTH-1:0] w_target;
  logic                           w_write;
  logic                           w_respond;

  // Round-robin search starting at the port after the last winner.
  always_comb begin
    w_grant     = 1'b0;
    w_winner    = '0;
    w_candidate = '0;
    for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
      w_candidate = PIW'((int'(r_next) + i) % NUMBER_OF_PORTS);
      if (!w_grant && bus.request_valid[w_candidate]) begin
        w_grant  = 1'b1;
        w_winner = w_candidate;
      end
    end
    w_grant = w_grant && (r_state == c_state_idle) && reset_n;
  end

  // Read data lags its address by one cycle, so the compare trails the counter.
  assign w_compare_index = r_count[TABLE_ADDRESS_WIDTH-1:0] - TABLE_ADDRESS_WIDTH'(1);
  assign w_match = (r_state == c_state_scan) && (r_count != '0) && r_valid[w_compare_index]
                   && (cam_table_read_data == r_mac) && !r_mac[40];

  always_comb begin
    w_free_found = 1'b0;
    w_free_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_index = TABLE_ADDRESS_WIDTH'(i);
      end
    end
  end

  assign w_target  = w_free_found ? w_free_index : r_victim;
  assign w_write   = (r_state == c_state_update) && !r_hit && !r_mac[40];
  assign w_respond = (r_state == c_state_respond);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_state_idle;
      r_count     <= '0;
      r_mac       <= '0;
      r_learn     <= 1'b0;
      r_requester <= '0;
      r_next      <= '0;
      r_valid     <= '0;
      r_victim    <= '0;
      r_hit       <= 1'b0;
      r_hit_index <= '0;
      r_hit_port  <= '0;
      for (int i = 0; i < DEPTH; i++) r_port[i] <= '0;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (w_grant) begin
            r_state     <= c_state_scan;
            r_count     <= '0;
            r_hit       <= 1'b0;
            r_mac       <= bus.request_mac[w_winner];
            r_learn     <= bus.request_learn[w_winner];
            r_requester <= w_winner;
            r_next      <= (w_winner == PIW'(NUMBER_OF_PORTS - 1)) ? '0 : w_winner + PIW'(1);
          end
        end
        c_state_scan: begin
          r_count <= r_count + COUNT_WIDTH'(1);
          if (w_match && !r_hit) begin
            r_hit       <= 1'b1;
            r_hit_index <= w_compare_index;
            r_hit_port  <= r_port[w_compare_index];
          end
          if (r_count == COUNT_WIDTH'(DEPTH)) r_state <= r_learn ? c_state_update : c_state_respond;
        end
        c_state_update: begin
          r_state <= c_state_respond;
          if (!r_mac[40]) begin
            if (r_hit) begin
              r_port[r_hit_index] <= r_requester;
            end else begin
              r_valid[w_target] <= 1'b1;
              r_port[w_target]  <= r_requester;
              if (!w_free_found) r_victim <= r_victim + TABLE_ADDRESS_WIDTH'(1);
            end
          end
        end
        c_state_respond: r_state <= c_state_idle;
        default:         r_state <= c_state_idle;
      endcase
    end
  end

  always_comb begin
    bus.request_ready = '0;
    if (w_grant) bus.request_ready[w_winner] = 1'b1;
  end

  assign bus.busy               = (r_state != c_state_idle) || w_grant;
  assign bus.response_valid     = w_respond;
  assign bus.response_requester = w_respond ? r_requester : '0;
  assign bus.response_hit       = w_respond && r_hit;
  assign bus.response_port      = (w_respond && r_hit) ? r_hit_port : '0;

  assign cam_table_read_address  = (r_state == c_state_scan) ? r_count[TABLE_ADDRESS_WIDTH-1:0] : '0;
  assign cam_table_write_enable  = w_write;
  assign cam_table_write_address = w_write ? w_target : '0;
  assign cam_table_write_data    = w_write ? r_mac : '0;
endmodule
`default_nettype wire
